// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: BLINK, SHIFT and EXPAND modes stepped on clk_div,
// with optional auto-advance between modes and direct mode jumps.
module led_pattern_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned BLINKS = 6
) (
    input  logic             clk_div,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             auto,
    input  logic             jmp,
    input  logic [1:0]       mode_sel,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       state,
    output logic             wrap
);

    localparam int unsigned HALF  = WIDTH / 2;
    localparam int unsigned OFF_W = $clog2(WIDTH) + 2;
    localparam int unsigned CNT_W = 8;

    localparam logic [WIDTH-1:0] LED_ON     = '1;
    localparam logic [WIDTH-1:0] LED_OFF    = '0;
    localparam logic [WIDTH-1:0] SHIFT_INIT = {HALF{2'b10}};
    localparam logic [WIDTH-1:0] EXP_INIT   = WIDTH'(3) << (HALF - 1);

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_EXPAND = 2'd2
    } mode_t;

    mode_t              mode_q, mode_d;
    logic [WIDTH-1:0]   led_q,  led_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic [OFF_W-1:0]   off_q,  off_d;   // two's complement, right-positive
    logic               wrap_q, wrap_d;
    logic               off_neg, off_pos;

    assign off_neg = off_q[OFF_W-1];
    assign off_pos = !off_q[OFF_W-1] && (off_q != '0);

    // State register with asynchronous reset
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_BLINK;
            led_q  <= LED_ON;
            cnt_q  <= '0;
            off_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            cnt_q  <= cnt_d;
            off_q  <= off_d;
            wrap_q <= wrap_d;
        end
    end

    // Next-state: hold when disabled, then jump, then per-mode stepping
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        cnt_d  = cnt_q;
        off_d  = off_q;
        wrap_d = 1'b0;

        if (!en) begin
            wrap_d = 1'b0;
        end else if (jmp && (mode_sel != 2'd3)) begin
            case (mode_sel)
                2'd0: begin
                    mode_d = MODE_BLINK;
                    led_d  = LED_ON;
                    cnt_d  = '0;
                end
                2'd1: begin
                    mode_d = MODE_SHIFT;
                    led_d  = SHIFT_INIT;
                    off_d  = '0;
                end
                default: begin
                    mode_d = MODE_EXPAND;
                    led_d  = EXP_INIT;
                end
            endcase
        end else begin
            case (mode_q)
                MODE_BLINK: begin
                    if (cnt_q == CNT_W'(BLINKS)) begin
                        wrap_d = 1'b1;
                        if (auto) begin
                            mode_d = MODE_SHIFT;
                            led_d  = SHIFT_INIT;
                            off_d  = '0;
                        end else begin
                            led_d = LED_ON;
                            cnt_d = '0;
                        end
                    end else if (led_q == LED_ON) begin
                        led_d = LED_OFF;
                    end else begin
                        led_d = LED_ON;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                MODE_SHIFT: begin
                    if (led_q == LED_OFF) begin
                        wrap_d = 1'b1;
                        off_d  = '0;
                        if (auto) begin
                            mode_d = MODE_EXPAND;
                            led_d  = EXP_INIT;
                        end else begin
                            led_d = SHIFT_INIT;
                        end
                    end else if (!dir) begin
                        // Right of home: plain shift; left of home: refill the pattern
                        led_d = off_neg ? {~led_q[WIDTH-1], led_q[WIDTH-1:1]}
                                        : {1'b0, led_q[WIDTH-1:1]};
                        off_d = off_q + OFF_W'(1);
                    end else begin
                        led_d = off_pos ? {led_q[WIDTH-2:0], ~led_q[0]}
                                        : {led_q[WIDTH-2:0], 1'b0};
                        off_d = off_q - OFF_W'(1);
                    end
                end

                MODE_EXPAND: begin
                    if (led_q == LED_ON) begin
                        wrap_d = 1'b1;
                        if (auto) begin
                            mode_d = MODE_BLINK;
                            led_d  = LED_OFF;
                            cnt_d  = '0;
                        end else begin
                            led_d = EXP_INIT;
                        end
                    end else if (!dir) begin
                        led_d = {led_q[WIDTH-2:HALF], 2'b11, led_q[HALF-1:1]};
                    end else if (led_q != LED_OFF) begin
                        led_d = {1'b0, led_q[WIDTH-1:HALF+1], led_q[HALF-2:0], 1'b0};
                    end else begin
                        led_d = LED_OFF;
                    end
                end

                default: begin
                    mode_d = MODE_BLINK;
                    led_d  = LED_ON;
                    cnt_d  = '0;
                    off_d  = '0;
                end
            endcase
        end
    end

    assign led   = led_q;
    assign state = mode_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: directed literal checks plus randomized stimulus
// compared each cycle against an abstract mode model (blink phase, offset, band).
module tb_led_pattern_seq;

    localparam int unsigned W = 16;
    localparam int unsigned B = 6;
    localparam int unsigned H = W / 2;

    logic         clk_div = 1'b0;
    logic         rst;
    logic         en;
    logic         dir;
    logic         auto;
    logic         jmp;
    logic [1:0]   mode_sel;
    logic [W-1:0] led;
    logic [1:0]   state;
    logic         wrap;

    int n_cmp = 0;
    int n_bad = 0;

    led_pattern_seq #(.WIDTH(W), .BLINKS(B)) dut (
        .clk_div  (clk_div),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .auto     (auto),
        .jmp      (jmp),
        .mode_sel (mode_sel),
        .led      (led),
        .state    (state),
        .wrap     (wrap)
    );

    always #5 clk_div = ~clk_div;

    // Abstract model: blink phase/count, signed shift offset, expand half-band k
    int m_mode = 0;
    int m_cnt  = 0;
    int m_off  = 0;
    int m_k    = 1;
    bit m_on   = 1'b1;
    bit m_wrap = 1'b0;

    function automatic logic [W-1:0] model_led();
        logic [W-1:0] init;
        logic [W-1:0] band;
        init = {H{2'b10}};
        band = '0;
        case (m_mode)
            0: return m_on ? {W{1'b1}} : {W{1'b0}};
            1: return (m_off >= 0) ? (init >> m_off) : (init << (-m_off));
            default: begin
                for (int i = 0; i < W; i++)
                    if (i >= int'(H) - m_k && i < int'(H) + m_k) band[i] = 1'b1;
                return band;
            end
        endcase
    endfunction

    always @(posedge clk_div or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_on = 1'b1; m_cnt = 0; m_off = 0; m_wrap = 1'b0;
        end else if (!en) begin
            m_wrap = 1'b0;
        end else if (jmp && mode_sel != 2'd3) begin
            m_wrap = 1'b0;
            m_mode = int'(mode_sel);
            if (mode_sel == 2'd0) begin m_on = 1'b1; m_cnt = 0; end
            else if (mode_sel == 2'd1) m_off = 0;
            else m_k = 1;
        end else begin
            m_wrap = 1'b0;
            case (m_mode)
                0: begin
                    if (m_cnt == int'(B)) begin
                        m_wrap = 1'b1;
                        if (auto) begin m_mode = 1; m_off = 0; end
                        else begin m_on = 1'b1; m_cnt = 0; end
                    end else if (m_on) m_on = 1'b0;
                    else begin m_on = 1'b1; m_cnt++; end
                end
                1: begin
                    if (model_led() == '0) begin
                        m_wrap = 1'b1;
                        m_off = 0;
                        if (auto) begin m_mode = 2; m_k = 1; end
                    end else if (dir) m_off--;
                    else m_off++;
                end
                default: begin
                    if (m_k == int'(H)) begin
                        m_wrap = 1'b1;
                        if (auto) begin m_mode = 0; m_on = 1'b0; m_cnt = 0; end
                        else m_k = 1;
                    end else if (dir) m_k = (m_k > 0) ? m_k - 1 : 0;
                    else m_k++;
                end
            endcase
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk_div) begin
        n_cmp++;
        if (led !== model_led() || state !== 2'(m_mode) || wrap !== m_wrap) begin
            n_bad++;
            $display("FAIL model t=%0t: led=%h state=%0d wrap=%0d, expected led=%h state=%0d wrap=%0d",
                     $time, led, state, wrap, model_led(), m_mode, m_wrap);
        end
    end

    task automatic step(input logic e, input logic d, input logic a,
                        input logic j, input logic [1:0] s);
        en = e; dir = d; auto = a; jmp = j; mode_sel = s;
        @(posedge clk_div);
        #2;
    endtask

    // Literal check of the DUT, and of the model at the same point
    task automatic chk(input string name, input logic [W-1:0] el,
                       input logic [1:0] es, input logic ew);
        n_cmp++;
        if (led !== el || state !== es || wrap !== ew) begin
            n_bad++;
            $display("FAIL %s: led=%h state=%0d wrap=%0d, expected led=%h state=%0d wrap=%0d",
                     name, led, state, wrap, el, es, ew);
        end
        n_cmp++;
        if (model_led() !== el || 2'(m_mode) !== es || m_wrap !== ew) begin
            n_bad++;
            $display("FAIL %s(model): led=%h state=%0d wrap=%0d, expected led=%h state=%0d wrap=%0d",
                     name, model_led(), m_mode, m_wrap, el, es, ew);
        end
    endtask

    logic [W-1:0] exp_seq [7];
    logic [W-1:0] aaaa;

    initial begin
        exp_seq = '{16'h03C0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'hFFFF};
        aaaa = 16'hAAAA;
        rst = 1'b1; en = 1'b0; dir = 1'b0; auto = 1'b1; jmp = 1'b0; mode_sel = 2'd3;
        repeat (3) @(posedge clk_div);
        #2;
        chk("reset", 16'hFFFF, 2'd0, 1'b0);
        rst = 1'b0;

        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 1, 0, 3);
            chk($sformatf("blink%0d", i), (i % 2 == 1) ? 16'h0000 : 16'hFFFF, 2'd0, 1'b0);
        end
        step(1, 0, 1, 0, 3); chk("blink_end", 16'hAAAA, 2'd1, 1'b1);

        step(1, 0, 1, 0, 3); chk("shr1", 16'h5555, 2'd1, 1'b0);
        step(1, 0, 1, 0, 3); chk("shr2", 16'h2AAA, 2'd1, 1'b0);
        step(1, 1, 1, 0, 3); chk("shl1", 16'h5555, 2'd1, 1'b0);
        step(1, 1, 1, 0, 3); chk("shl2", 16'hAAAA, 2'd1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 1, 0, 3);
            chk($sformatf("shr_run%0d", i), aaaa >> i, 2'd1, 1'b0);
        end
        step(1, 0, 1, 0, 3); chk("shift_end", 16'h0180, 2'd2, 1'b1);

        for (int i = 0; i < 7; i++) begin
            step(1, 0, 1, 0, 3);
            chk($sformatf("expand%0d", i), exp_seq[i], 2'd2, 1'b0);
        end
        step(1, 0, 1, 0, 3); chk("expand_end", 16'h0000, 2'd0, 1'b1);

        step(1, 0, 1, 1, 2); chk("jmp_expand", 16'h0180, 2'd2, 1'b0);
        step(1, 0, 1, 0, 3); chk("exp_grow", 16'h03C0, 2'd2, 1'b0);
        step(1, 1, 1, 0, 3); chk("contract1", 16'h0180, 2'd2, 1'b0);
        step(1, 1, 1, 0, 3); chk("contract2", 16'h0000, 2'd2, 1'b0);
        step(1, 1, 1, 0, 3); chk("contract_hold", 16'h0000, 2'd2, 1'b0);

        step(1, 0, 0, 1, 1); chk("jmp_shift", 16'hAAAA, 2'd1, 1'b0);
        for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, 3);
        chk("noauto_zero", 16'h0000, 2'd1, 1'b0);
        step(1, 0, 0, 0, 3); chk("noauto_reload", 16'hAAAA, 2'd1, 1'b1);
        step(1, 0, 0, 0, 3); chk("noauto_next", 16'h5555, 2'd1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 1, 0);
            chk($sformatf("hold%0d", i), 16'h5555, 2'd1, 1'b0);
        end
        step(1, 0, 0, 0, 3); chk("resume", 16'h2AAA, 2'd1, 1'b0);

        rst = 1'b1;
        #1;
        chk("async_rst", 16'hFFFF, 2'd0, 1'b0);
        rst = 1'b0;
        step(1, 0, 1, 0, 3); chk("post_rst", 16'h0000, 2'd0, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            if ($urandom_range(0, 15) == 0) auto = ~auto;
            jmp = ($urandom_range(0, 24) == 0);
            mode_sel = 2'($urandom_range(0, 3));
            @(posedge clk_div);
            #2;
        end
        rst = 1'b0;
        @(posedge clk_div);
        #6;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 Parameter WIDTH, default 16, LED count; SHALL be even and >= 4.
REQ-002 Parameter BLINKS, default 6, number of ON phases counted in BLINK mode, range 1..255.
REQ-003 clk_div  input  1  pre-divided step clock; all state advances on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  step enable; 0 freezes all state and outputs.
REQ-006 dir  input  1  direction: SHIFT 1=left, 0=right; EXPAND 1=contract, 0=expand.
REQ-007 auto  input  1  1 = advance BLINK->SHIFT->EXPAND->BLINK; 0 = repeat the current mode.
REQ-008 jmp  input  1  sampled each step; request to jump to the mode given by mode_sel.
REQ-009 mode_sel  input  2  jump target: 0 BLINK, 1 SHIFT, 2 EXPAND, 3 no jump.
REQ-010 led  output  WIDTH  LED pattern, registered.
REQ-011 state  output  2  current mode: 0 BLINK, 1 SHIFT, 2 EXPAND.
REQ-012 wrap  output  1  registered one-step pulse, high for the step after a mode end (advance or reload).

Function
REQ-013 Defined constants: ON = all ones; OFF = all zeros; SHIFT_INIT = {WIDTH/2{2'b10}}; EXP_INIT = only bits WIDTH/2 and WIDTH/2-1 set.
REQ-014 Priority per step: en=0 (hold everything, wrap=0), then jmp with mode_sel != 3, then normal mode behaviour.
REQ-015 Jump: state = mode_sel; led = that mode's entry value (BLINK: ON with cnt=0; SHIFT: SHIFT_INIT with off=0; EXPAND: EXP_INIT); wrap = 0.
REQ-016 BLINK: if cnt == BLINKS, end of mode. Otherwise, if led == ON then led = OFF; else led = ON and cnt = cnt+1.
REQ-017 BLINK end: auto=1 gives state SHIFT, led = SHIFT_INIT, off = 0. auto=0 gives led = ON, cnt = 0. Both cases set wrap = 1.
REQ-018 SHIFT keeps a signed offset off, width clog2(WIDTH)+2, for net displacement (right positive).
REQ-019 SHIFT, dir=0: if off >= 0, led = led >> 1 with 0 fill; else fill MSB with ~led[WIDTH-1]. Then off = off+1.
REQ-020 SHIFT, dir=1: if off <= 0, led = led << 1 with 0 fill; else fill LSB with ~led[0]. Then off = off-1. Reversing direction therefore restores the alternating pattern.
REQ-021 SHIFT end when led == OFF at the start of a step: auto=1 gives state EXPAND, led = EXP_INIT. auto=0 gives led = SHIFT_INIT. In both cases off = 0 and wrap = 1.
REQ-022 EXPAND, dir=0: led = {led[WIDTH-2:WIDTH/2], 2'b11, led[WIDTH/2-1:1]}, i.e. grows outward by one bit on each side.
REQ-023 EXPAND, dir=1: if led != OFF, led = {0, led[WIDTH-1:WIDTH/2+1], led[WIDTH/2-2:0], 0}. If led == OFF, hold OFF. Expanding from OFF yields EXP_INIT.
REQ-024 EXPAND end when led == ON at the start of a step: auto=1 gives state BLINK, led = OFF, cnt = 0. auto=0 gives led = EXP_INIT. Both cases set wrap = 1.
REQ-025 Mode-end checks use the registered led value. dir and auto changes take effect on the next step with no extra latency.
REQ-026 wrap SHALL be 0 on every step that is not a mode end, including jump steps.

Reset
REQ-027 When rst is asserted, immediately and independently of clk_div: led = ON, state = BLINK, cnt = 0, off = 0, wrap = 0.
REQ-028 Reset mid-mode SHALL discard all progress. The first step after release follows REQ-016 (led = OFF).

Verification (WIDTH=16, BLINKS=6)
REQ-029 Reset, then en=1, auto=1: led alternates FFFF/0000. At step 12 led = FFFF with cnt = 6. At step 13 led = AAAA, state = 1, wrap = 1.
REQ-030 From AAAA with dir=0: 5555, then 2AAA. Flip dir=1: 5555, then AAAA (off back to 0). Hold dir=0 for 16 steps: led = 0000. Next step: led = 0180, state = 2.
REQ-031 EXPAND with dir=0 from 0180: 03C0, 07E0, 0FF0, 1FF8, 3FFC, 7FFE, FFFF. Next step: led = 0000, state = 0, wrap = 1. With dir=1 from 03C0: 0180, 0000, then held at 0000.
REQ-032 auto=0 in SHIFT, led reaches 0000: next step led = AAAA, state stays 1, wrap = 1 for one step.
REQ-033 en=0 for 5 steps mid-SHIFT: led, state and off unchanged, wrap = 0. jmp=1, en=0 is ignored.
REQ-034 jmp=1, mode_sel=2 during BLINK: next step led = 0180, state = 2, wrap = 0. Asserting rst between clk_div edges: led = FFFF before the next edge.
